// File: rtl/prime_arb_pkg.sv
// Shared types and default sizing for the prime query arbiter.
package prime_arb_pkg;

    localparam int N_DEF        = 8;
    localparam int WAIT_MAX_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUILD  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        LOOKUP = 3'd4,
        RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/prime_query_arb_if.sv
// Requester and sieve-side bundle of the prime query arbiter.
import prime_arb_pkg::*;

interface prime_query_arb_if #(
    parameter int N = N_DEF
);
    logic [1:0]     req_valid;
    logic [2*N-1:0] req_k;
    logic [1:0]     grant;
    logic [1:0]     resp_valid;
    logic           resp_prime;
    logic           resp_err;
    logic           pg_start;
    logic [N-1:0]   pg_num;
    logic [N-1:0]   pg_k;
    logic           pg_rdy;
    logic           pg_p;
    logic [N-1:0]   bound;
    logic           bound_ok;

    modport slave (
        input  req_valid, req_k, pg_rdy, pg_p,
        output grant, resp_valid, resp_prime, resp_err,
               pg_start, pg_num, pg_k, bound, bound_ok
    );

    modport master (
        output req_valid, req_k, pg_rdy, pg_p,
        input  grant, resp_valid, resp_prime, resp_err,
               pg_start, pg_num, pg_k, bound, bound_ok
    );
endinterface

// File: rtl/prime_rr_arb2.sv
// Two-requester round-robin choice; 'last' is the index granted most recently.
module prime_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the requester that was not served last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/prime_query_arb.sv
// Arbitrates two requesters onto one prime sieve, rebuilding the sieve when a
// query exceeds the current bound and answering trivial numbers directly.
module prime_query_arb
    import prime_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input logic              clk,
    input logic              rst,
    prime_query_arb_if.slave bus
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    state_t         state_r, state_n;
    logic           idx_r, idx_n;
    logic           last_r, last_n;
    logic [N-1:0]   k_r, k_n;
    logic [WCW-1:0] wait_cnt_r, wait_cnt_n;
    logic [WCW-1:0] wait_inc_s;
    logic [N-1:0]   bound_r, bound_n;
    logic           bound_ok_r, bound_ok_n;
    logic           is_lookup_r, is_lookup_n;
    logic           triv_prime_r, triv_prime_n;
    logic           err_r, err_n;
    logic [1:0]     resp_valid_r;
    logic           resp_err_r;
    logic           pg_start_r;
    logic [N-1:0]   pg_num_r;
    logic [N-1:0]   pg_k_r;
    logic [1:0]     rr_gnt_s;
    logic [1:0]     grant_s;
    logic           sel_idx_s;
    logic [N-1:0]   sel_k_s;

    // 0, 1 and every even number are answered without the sieve.
    function automatic logic is_trivial(input logic [N-1:0] k);
        return (k < N'(2)) || (k[0] == 1'b0);
    endfunction

    prime_rr_arb2 u_rr (
        .req  (bus.req_valid),
        .last (last_r),
        .gnt  (rr_gnt_s)
    );

    assign sel_idx_s  = rr_gnt_s[1];
    assign sel_k_s    = sel_idx_s ? bus.req_k[2*N-1:N] : bus.req_k[N-1:0];
    assign wait_inc_s = wait_cnt_r + WCW'(1);

    // Next-state, latched query context and grant decode.
    always_comb begin
        state_n      = state_r;
        idx_n        = idx_r;
        last_n       = last_r;
        k_n          = k_r;
        wait_cnt_n   = wait_cnt_r;
        bound_n      = bound_r;
        bound_ok_n   = bound_ok_r;
        is_lookup_n  = is_lookup_r;
        triv_prime_n = triv_prime_r;
        err_n        = err_r;
        grant_s      = 2'b00;
        case (state_r)
            IDLE: begin
                if (!rst && (rr_gnt_s != 2'b00)) begin
                    grant_s = rr_gnt_s;
                    idx_n   = sel_idx_s;
                    last_n  = sel_idx_s;
                    k_n     = sel_k_s;
                    err_n   = 1'b0;
                    if (is_trivial(sel_k_s)) begin
                        state_n      = RESP;
                        is_lookup_n  = 1'b0;
                        triv_prime_n = (sel_k_s == N'(2));
                    end else if (bound_ok_r && (sel_k_s <= bound_r)) begin
                        state_n      = LOOKUP;
                        is_lookup_n  = 1'b1;
                        triv_prime_n = 1'b0;
                    end else begin
                        state_n      = BUILD;
                        is_lookup_n  = 1'b1;
                        triv_prime_n = 1'b0;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            BUILD: begin
                bound_n    = k_r;
                bound_ok_n = 1'b0;
                state_n    = SETTLE;
            end
            SETTLE: begin
                wait_cnt_n = {WCW{1'b0}};
                state_n    = WAIT;
            end
            WAIT: begin
                wait_cnt_n = wait_inc_s;
                if (bus.pg_rdy) begin
                    bound_ok_n = 1'b1;
                    state_n    = LOOKUP;
                end else if (wait_inc_s == WCW'(WAIT_MAX)) begin
                    err_n       = 1'b1;
                    is_lookup_n = 1'b0;
                    state_n     = RESP;
                end else begin
                    state_n = WAIT;
                end
            end
            LOOKUP:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, context and outputs; outputs are decoded from the next state so
    // they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= 1'b0;
            last_r       <= 1'b1;
            k_r          <= {N{1'b0}};
            wait_cnt_r   <= {WCW{1'b0}};
            bound_r      <= {N{1'b0}};
            bound_ok_r   <= 1'b0;
            is_lookup_r  <= 1'b0;
            triv_prime_r <= 1'b0;
            err_r        <= 1'b0;
            resp_valid_r <= 2'b00;
            resp_err_r   <= 1'b0;
            pg_start_r   <= 1'b0;
            pg_num_r     <= {N{1'b0}};
            pg_k_r       <= {N{1'b0}};
        end else begin
            state_r      <= state_n;
            idx_r        <= idx_n;
            last_r       <= last_n;
            k_r          <= k_n;
            wait_cnt_r   <= wait_cnt_n;
            bound_r      <= bound_n;
            bound_ok_r   <= bound_ok_n;
            is_lookup_r  <= is_lookup_n;
            triv_prime_r <= triv_prime_n;
            err_r        <= err_n;
            resp_valid_r <= (state_n == RESP) ? (idx_n ? 2'b10 : 2'b01) : 2'b00;
            resp_err_r   <= (state_n == RESP) && err_n;
            pg_start_r   <= (state_n == BUILD);
            pg_num_r     <= (state_n == BUILD) ? k_n : pg_num_r;
            pg_k_r       <= ((state_n == LOOKUP) || (state_n == RESP)) ? k_n : {N{1'b0}};
        end
    end

    assign bus.grant      = grant_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_prime = (resp_valid_r != 2'b00) && !resp_err_r &&
                            (is_lookup_r ? bus.pg_p : triv_prime_r);
    assign bus.pg_start   = pg_start_r;
    assign bus.pg_num     = pg_num_r;
    assign bus.pg_k       = pg_k_r;
    assign bus.bound      = bound_r;
    assign bus.bound_ok   = bound_ok_r;

endmodule

// File: tb/tb_prime_query_arb.sv
// Directed bench for prime_query_arb with a small behavioural sieve model.
module tb_prime_query_arb;

    localparam int N    = 8;
    localparam int WMAX = 16;

    logic clk = 1'b0;
    logic rst;
    logic stuck;
    logic sieve_busy;
    int   sieve_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    prime_query_arb_if #(.N(N)) bus ();

    prime_query_arb #(.N(N), .WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic is_prime8(input logic [7:0] v);
        if (v < 8'd2) return 1'b0;
        for (int d = 2; d * d <= int'(v); d++)
            if ((int'(v) % d) == 0) return 1'b0;
        return 1'b1;
    endfunction

    assign bus.pg_p = is_prime8(bus.pg_k);

    // Sieve model: ready three posedges after the start pulse unless stuck.
    always @(posedge clk) begin
        if (rst) begin
            bus.pg_rdy <= 1'b0;
            sieve_busy <= 1'b0;
            sieve_cnt  <= 0;
        end else if (bus.pg_start) begin
            bus.pg_rdy <= 1'b0;
            sieve_busy <= 1'b1;
            sieve_cnt  <= 2;
        end else if (sieve_busy && !stuck) begin
            if (sieve_cnt == 0) begin
                bus.pg_rdy <= 1'b1;
                sieve_busy <= 1'b0;
            end else begin
                sieve_cnt <= sieve_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " grant"},      32'(bus.grant),      32'd0);
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " resp_prime"}, 32'(bus.resp_prime), 32'd0);
        check({tag, " resp_err"},   32'(bus.resp_err),   32'd0);
        check({tag, " pg_start"},   32'(bus.pg_start),   32'd0);
        check({tag, " pg_num"},     32'(bus.pg_num),     32'd0);
        check({tag, " pg_k"},       32'(bus.pg_k),       32'd0);
        check({tag, " bound"},      32'(bus.bound),      32'd0);
        check({tag, " bound_ok"},   32'(bus.bound_ok),   32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One request; latency counted from the grant cycle to the resp cycle.
    task automatic query(input int idx, input logic [7:0] k, input logic exp_prime,
                         input logic exp_err, input int exp_lat, input logic exp_build,
                         input string tag);
        int   gcyc;
        int   ngrant;
        logic done;
        logic saw_start;
        @(posedge clk);
        #1;
        bus.req_valid[idx]     = 1'b1;
        bus.req_k[idx*N +: N]  = k;
        gcyc      = -1;
        ngrant    = 0;
        done      = 1'b0;
        saw_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (bus.grant != 2'b00) begin
                ngrant++;
                gcyc = cyc;
                check({tag, " grant"}, 32'(bus.grant), 32'(1 << idx));
            end
            if (bus.pg_start) begin
                saw_start = 1'b1;
                check({tag, " pg_num"}, 32'(bus.pg_num), 32'(k));
            end
            if (bus.resp_valid != 2'b00) begin
                check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'(1 << idx));
                check({tag, " resp_prime"}, 32'(bus.resp_prime), 32'(exp_prime));
                check({tag, " resp_err"},   32'(bus.resp_err),   32'(exp_err));
                check({tag, " pg_k"},       32'(bus.pg_k),       32'(k));
                check({tag, " latency"},    32'(cyc - gcyc),     32'(exp_lat));
                bus.req_valid[idx] = 1'b0;
                done = 1'b1;
            end
        end
        check({tag, " done"},      32'(done),      32'd1);
        check({tag, " one_grant"}, 32'(ngrant),    32'd1);
        check({tag, " pg_start"},  32'(saw_start), 32'(exp_build));
    endtask

    initial begin
        logic [1:0] gseq [4];
        int         gi;
        logic       seen_start;
        logic       any_resp;
        logic       multi;

        rst           = 1'b1;
        stuck         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_k     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // Rebuild from the empty sieve, then in-bound lookup and a rebuild.
        query(0, 8'd7, 1'b1, 1'b0, 7, 1'b1, "k7");
        check("k7 bound",    32'(bus.bound),    32'd7);
        check("k7 bound_ok", 32'(bus.bound_ok), 32'd1);
        query(1, 8'd5, 1'b1, 1'b0, 2, 1'b0, "k5");
        query(1, 8'd9, 1'b0, 1'b0, 7, 1'b1, "k9");
        check("k9 bound", 32'(bus.bound), 32'd9);

        query(0, 8'd0, 1'b0, 1'b0, 1, 1'b0, "k0");
        query(0, 8'd1, 1'b0, 1'b0, 1, 1'b0, "k1");
        query(0, 8'd2, 1'b1, 1'b0, 1, 1'b0, "k2");
        query(0, 8'd4, 1'b0, 1'b0, 1, 1'b0, "k4");

        // Full-width bound, then an in-bound prime near the top.
        query(0, 8'd255, 1'b0, 1'b0, 7, 1'b1, "k255");
        check("k255 bound", 32'(bus.bound), 32'd255);
        query(1, 8'd251, 1'b1, 1'b0, 2, 1'b0, "k251");

        // Sieve never ready: 16 WAIT cycles then an error response.
        do_reset();
        stuck = 1'b1;
        query(0, 8'd13, 1'b0, 1'b1, 19, 1'b1, "tmo");
        check("tmo bound_ok", 32'(bus.bound_ok), 32'd0);
        check("tmo bound",    32'(bus.bound),    32'd13);

        // Reset while waiting on the sieve abandons the query.
        do_reset();
        @(posedge clk);
        #1;
        bus.req_valid[0]  = 1'b1;
        bus.req_k[N-1:0]  = 8'd11;
        seen_start = 1'b0;
        for (int c = 0; c < 20 && !seen_start; c++) begin
            @(negedge clk);
            seen_start = bus.pg_start;
        end
        check("rstw start", 32'(seen_start), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        check_reset_vals("rstw");
        rst = 1'b0;
        any_resp = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) any_resp = 1'b1;
        end
        check("rstw no_resp", 32'(any_resp), 32'd0);

        // Both requesters permanently valid: grants must alternate.
        stuck = 1'b0;
        do_reset();
        @(posedge clk);
        #1;
        bus.req_k     = {8'd3, 8'd3};
        bus.req_valid = 2'b11;
        gi    = 0;
        multi = 1'b0;
        for (int c = 0; c < 150 && gi < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid == 2'b11 || bus.grant == 2'b11) multi = 1'b1;
            if (bus.grant != 2'b00) begin
                gseq[gi] = bus.grant;
                gi++;
            end
        end
        bus.req_valid = 2'b00;
        check("rr count", 32'(gi), 32'd4);
        if (gi == 4) begin
            check("rr g0", 32'(gseq[0]), 32'd1);
            check("rr g1", 32'(gseq[1]), 32'd2);
            check("rr g2", 32'(gseq[2]), 32'd1);
            check("rr g3", 32'(gseq[3]), 32'd2);
        end
        check("rr onehot", 32'(multi), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prime_query_arb.md
PRIME_QUERY_ARB -- requirements
Module: prime_query_arb

Interface
REQ-001 SHALL have parameter N, default 8, meaning bit width of queried numbers and sieve bound.
REQ-002 SHALL have parameter WAIT_MAX, default 4096, meaning the maximum number of cycles spent waiting for pg_rdy before aborting.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester query request; held until that requester's resp_valid.
REQ-006 SHALL have port req_k  input  2*N  query numbers; requester i occupies bits [i*N +: N]; held with req_valid.
REQ-007 SHALL have port grant  output  2  one-cycle pulse acknowledging acceptance of requester i's query.
REQ-008 SHALL have port resp_valid  output  2  one-cycle pulse: answer for requester i is on resp_prime/resp_err.
REQ-009 SHALL have port resp_prime  output  1  1 = queried k is prime; valid only with resp_valid.
REQ-010 SHALL have port resp_err  output  1  1 = sieve timed out, resp_prime forced 0; valid only with resp_valid.
REQ-011 SHALL have port pg_start, pg_num[N-1:0], pg_k[N-1:0]  output  sieve control: start pulse, bound, lookup address.
REQ-012 SHALL have port pg_rdy, pg_p  input  1 each  sieve finished; lookup result (1 = prime bitmap entry).
REQ-013 SHALL have port bound  output  N  current sieve bound; bound_ok output 1 = sieve contents valid up to bound.

Function
REQ-014 SHALL implement FSM states IDLE, BUILD, SETTLE, WAIT, LOOKUP, RESP.
REQ-015 SHALL, in IDLE, grant one valid requester per round-robin: if both are valid, the one not granted last wins; latch index and k; pulse grant.
REQ-016 SHALL classify latched k: k<2 or even k>2 -> not prime; k==2 -> prime; both are trivial and go IDLE->RESP without touching the sieve.
REQ-017 SHALL, for odd k>=3: go to LOOKUP if bound_ok and k<=bound, else go to BUILD.
REQ-018 SHALL, in BUILD, assert pg_start for exactly one cycle with pg_num=k, set bound<=k, clear bound_ok; next state SETTLE.
REQ-019 SHALL spend exactly one cycle in SETTLE (pg_start=0, pg_rdy ignored); next state WAIT.
REQ-020 SHALL, in WAIT, go to LOOKUP and set bound_ok when pg_rdy=1, and count the cycles spent in WAIT.
REQ-021 SHALL, when the WAIT count reaches WAIT_MAX, go to RESP with resp_err=1, leaving bound_ok=0.
REQ-022 SHALL drive pg_k=latched k during LOOKUP and RESP; pg_k=0 otherwise.
REQ-023 SHALL, in RESP, sample pg_p for lookup queries, pulse resp_valid[idx] with the result, then return to IDLE.
REQ-024 SHALL have latency: trivial k = grant+1 cycle; in-bound lookup = grant+2; rebuild = grant+4+WAIT cycles.
REQ-025 SHALL compare k with bound unsigned at full N bits; k=2^N-1 is legal and triggers a rebuild with pg_num=2^N-1.
REQ-026 SHALL ignore req_valid deassertion after grant and still issue the response; requests arriving while busy wait in IDLE.
REQ-027 SHALL never assert grant outside IDLE, or more than one grant/resp_valid bit at a time.

Reset
REQ-028 SHALL, on rst=1 at a clock edge: state IDLE, grant=0, resp_valid=0, resp_prime=0, resp_err=0, pg_start=0, pg_num=0, pg_k=0, bound=0, bound_ok=0, WAIT counter=0, round-robin priority to requester 0.
REQ-029 SHALL, on rst mid-operation (any state), abandon the in-flight query with no response; pg_start low from the next cycle.

Structure
REQ-030 SHALL place the state enum and the default N/WAIT_MAX constants in shared package prime_arb_pkg.
REQ-031 SHALL implement the two-input round-robin choice as sub-module prime_rr_arb2 (req[1:0], last, gnt[1:0]).

Verification
REQ-032 SHALL verify: after reset, req0 with k=7 -> BUILD with pg_num=7, then resp_valid[0], resp_prime=1, bound=7, bound_ok=1.
REQ-033 SHALL verify: with bound=7 valid, req1 with k=5 -> no pg_start, resp_valid[1] at grant+2, resp_prime=1; k=9 -> rebuild with pg_num=9, resp_prime=0.
REQ-034 SHALL verify: k=0, 1, 2, 4 -> resp at grant+1 with resp_prime 0, 0, 1, 0; pg_start never asserted.
REQ-035 SHALL verify: both requesters valid continuously with k=3 -> grants alternate 0,1,0,1.
REQ-036 SHALL verify: pg_rdy stuck 0, WAIT_MAX=16 -> resp_err=1, resp_prime=0 after 16 WAIT cycles, bound_ok=0.
REQ-037 SHALL verify: rst asserted during WAIT -> next cycle all outputs at reset values and no resp_valid ever issued.
